mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: number of busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: number of busy cycles for div/divu.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  E-stage issue strobe; qualifies MDOp.
REQ-006 Port MDOp  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-007 Port A  input  32  forwarded rs operand (MFRSE path).
REQ-008 Port B  input  32  forwarded rt operand (MFRTE path).
REQ-009 Port busy  output  1  operation in progress.
REQ-010 Port HI  output  32  HI register, registered.
REQ-011 Port LO  output  32  LO register, registered.

Function
REQ-012 Commands SHALL be accepted only on a cycle with start=1, busy=0, and MDOp in 1..6; all other start pulses are ignored with no state change.
REQ-013 On acceptance of ops 1-4, A and B SHALL be latched internally; later changes on A/B have no effect on the result.
REQ-014 Accepted ops 1-2 at edge T SHALL drive busy=1 for exactly MULT_CYCLES cycles (T+1..T+MULT_CYCLES); ops 3-4 for exactly DIV_CYCLES cycles.
REQ-015 HI/LO SHALL update at the same edge where busy falls; new values visible in the first cycle with busy=0; HI/LO hold their old values throughout busy.
REQ-016 A new operation SHALL be acceptable in the first cycle busy=0 (back-to-back issue, no dead cycle).
REQ-017 mult: {HI,LO} = signed(A) * signed(B), full 64-bit product; multu: unsigned 64-bit product.
REQ-018 div: LO = quotient truncated toward zero, HI = remainder with sign of dividend A; divu: unsigned quotient/remainder.
REQ-019 div with A=0x80000000, B=0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-020 div/divu with B=0 SHALL still occupy busy for DIV_CYCLES cycles and leave HI and LO unchanged.
REQ-021 mthi SHALL write HI=A and mtlo LO=A at the accepting edge, visible next cycle, no busy assertion, other register untouched.
REQ-022 mthi/mtlo presented while busy=1 SHALL be ignored (the hazard unit stalls them; stall condition is start|busy for any MD instruction in E).
REQ-023 State machine: IDLE -> MUL (ops 1-2) or DIV (ops 3-4); MUL/DIV count down a cycle counter loaded with N-1, return to IDLE and commit when the counter reaches 0.
REQ-024 busy SHALL be a registered output decoded from state (busy = state != IDLE), never combinational on start.
REQ-025 Internal arithmetic may be combinational on latched operands or iterative, provided REQ-014/015 cycle counts and REQ-017..020 results hold exactly.

Reset
REQ-026 While reset=1 at a rising edge: state=IDLE, counter=0, busy=0, HI=0x00000000, LO=0x00000000.
REQ-027 Reset asserted mid-operation SHALL abort it with no commit; reset outranks start on the same edge.
REQ-028 Internal operand latches need no reset value, but SHALL never reach HI/LO without a completed operation.

Verification
REQ-029 mult A=0xFFFFFFFE (-2), B=0x00000003, start 1 cycle -> busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 div A=0xFFFFFFF9 (-7), B=0x00000002 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; back-to-back divu 7/2 issued on the first idle cycle -> LO=3, HI=1 ten cycles later.
REQ-032 mthi A=0x12345678 then divu B=0 -> HI stays 0x12345678, LO unchanged, busy 10 cycles; mtlo issued during busy -> LO unchanged.
REQ-033 mult issued, reset asserted on 3rd busy cycle -> next cycle busy=0, HI=LO=0, no later commit.
REQ-034 start=1 with MDOp=7 or MDOp=0 while idle -> busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/mdu.sv
// rtl/mdu.sv - multiply/divide unit with HI/LO registers
// Fixed-latency mult/div; result commits to HI/LO on the edge where busy falls.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic          r_signed;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic          w_accept;
  logic          w_done;
  logic [63:0]   w_a_ext;
  logic [63:0]   w_b_ext;
  logic [63:0]   w_prod;
  logic          w_a_neg;
  logic          w_b_neg;
  logic [31:0]   w_a_mag;
  logic [31:0]   w_b_mag;
  logic [31:0]   w_uq;
  logic [31:0]   w_ur;
  logic [31:0]   w_quot;
  logic [31:0]   w_rem;

  assign w_accept = start && (r_state == S_IDLE) && (MDOp >= OP_MULT) && (MDOp <= OP_MTLO);
  assign w_done   = (r_state != S_IDLE) && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (MDOp == OP_MULT || MDOp == OP_MULTU)) begin
          w_next = S_MUL;
        end else if (w_accept && (MDOp == OP_DIV || MDOp == OP_DIVU)) begin
          w_next = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (w_done) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Sign-extending only for signed ops lets one 64x64 multiply cover both flavours.
  assign w_a_ext = {{32{r_signed & r_a[31]}}, r_a};
  assign w_b_ext = {{32{r_signed & r_b[31]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Magnitude divide; 0x80000000 / -1 wraps back to 0x80000000 with no special case.
  assign w_a_neg = r_signed & r_a[31];
  assign w_b_neg = r_signed & r_b[31];
  assign w_a_mag = w_a_neg ? (~r_a + 32'd1) : r_a;
  assign w_b_mag = w_b_neg ? (~r_b + 32'd1) : r_b;
  assign w_uq    = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
  assign w_ur    = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);
  assign w_quot  = (w_a_neg ^ w_b_neg) ? (~w_uq + 32'd1) : w_uq;
  assign w_rem   = w_a_neg ? (~w_ur + 32'd1) : w_ur;

  always_ff @(posedge clk) begin
    if (w_accept && (MDOp >= OP_MULT) && (MDOp <= OP_DIVU)) begin
      r_a      <= A;
      r_b      <= B;
      r_signed <= (MDOp == OP_MULT) || (MDOp == OP_DIV);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        case (MDOp)
          OP_MULT, OP_MULTU: r_cnt <= MUL_LOAD;
          OP_DIV, OP_DIVU:   r_cnt <= DIV_LOAD;
          OP_MTHI:           r_hi  <= A;
          OP_MTLO:           r_lo  <= A;
          default:           r_cnt <= r_cnt;
        endcase
      end
    end else if (w_done) begin
      if (r_state == S_MUL) begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end else if (r_b != 32'd0) begin
        r_hi <= w_rem;
        r_lo <= w_quot;
      end
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - randomized self-checking bench for mdu
// Reference model tracks remaining busy cycles and a pending HI/LO result.
module tb_mdu;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks;
  int n_errors;

  int          m_left;
  logic        m_pv;
  logic [31:0] m_phi;
  logic [31:0] m_plo;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic st, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    longint      p;
    longint      q;
    longint      r;
    logic [63:0] up;
    sa = a;
    sb = b;
    if (rst) begin
      m_left = 0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pv) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (st) begin
      case (op)
        3'd1: begin
          p = longint'(sa) * longint'(sb);
          m_phi = p[63:32]; m_plo = p[31:0]; m_pv = 1'b1; m_left = MULT_CYCLES;
        end
        3'd2: begin
          up = {32'd0, a} * {32'd0, b};
          m_phi = up[63:32]; m_plo = up[31:0]; m_pv = 1'b1; m_left = MULT_CYCLES;
        end
        3'd3, 3'd4: begin
          m_left = DIV_CYCLES;
          m_pv   = (b != 32'd0);
          if (b != 32'd0) begin
            if (op == 3'd3) begin
              q = longint'(sa) / longint'(sb);
              r = longint'(sa) % longint'(sb);
            end else begin
              q = longint'({32'd0, a}) / longint'({32'd0, b});
              r = longint'({32'd0, a}) % longint'({32'd0, b});
            end
            m_plo = q[31:0];
            m_phi = r[31:0];
          end
        end
        3'd5: m_hi = a;
        3'd6: m_lo = a;
        default: m_left = 0;
      endcase
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    reset = rst;
    start = st;
    MDOp  = op;
    A     = a;
    B     = b;
    @(posedge clk);
    model_edge(rst, st, op, a, b);
    #1;
    check("busy", {31'd0, busy}, {31'd0, m_left > 0});
    check("hi", HI, m_hi);
    check("lo", LO, m_lo);
  endtask

  task automatic idle_until_free();
    int guard;
    guard = 0;
    while (m_left > 0 && guard < 40) begin
      step(1'b0, 1'b0, 3'd0, $urandom, $urandom);
      guard++;
    end
    check("idle_bound", {31'd0, busy}, 32'd0);
  endtask

  task automatic count_busy(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (busy && n < 40) begin
      n++;
      step(1'b0, 1'b0, 3'd0, $urandom, $urandom);
    end
    check(tag, n, exp_cycles);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_left = 0; m_pv = 1'b0; m_phi = '0; m_plo = '0; m_hi = '0; m_lo = '0;
    reset = 1'b1; start = 1'b0; MDOp = 3'd0; A = '0; B = '0;

    step(1'b1, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0);
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);

    // signed multiply, operands change during busy
    step(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3);
    count_busy("mult_busy_len", MULT_CYCLES);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    step(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    count_busy("multu_busy_len", MULT_CYCLES);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    step(1'b0, 1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);
    count_busy("div_busy_len", DIV_CYCLES);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 3'd4, 32'd7, 32'd2);
    count_busy("divu_b2b_len", DIV_CYCLES);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    step(1'b0, 1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy("ovf_busy_len", DIV_CYCLES);
    check("ovf_lo", LO, 32'h8000_0000);
    check("ovf_hi", HI, 32'd0);

    step(1'b0, 1'b1, 3'd5, 32'h1234_5678, 32'd0);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_lo", LO, 32'h8000_0000);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    step(1'b0, 1'b1, 3'd4, 32'd99, 32'd0);
    step(1'b0, 1'b1, 3'd6, 32'hAAAA_5555, 32'd0);
    count_busy("div0_busy_len", DIV_CYCLES - 1);
    check("div0_hi", HI, 32'h1234_5678);
    check("div0_lo", LO, 32'h8000_0000);

    // reset on the third busy cycle aborts the multiply
    step(1'b0, 1'b1, 3'd1, 32'd1000, 32'd1000);
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 3'd5, 32'h5555_5555, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd0, $urandom, $urandom);
    check("abort_nocommit", LO, 32'd0);

    step(1'b0, 1'b1, 3'd6, 32'h0BAD_F00D, 32'd0);
    step(1'b0, 1'b1, 3'd7, 32'h1111_1111, 32'd0);
    step(1'b0, 1'b1, 3'd0, 32'h2222_2222, 32'd0);
    check("op7_0_lo", LO, 32'h0BAD_F00D);
    check("op7_0_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
           3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end
    idle_until_free();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
